// File: rtl/ps_setpoint_converter.sv
`default_nettype none
// ============================================================================
// Module  : ps_setpoint_converter
// Brief   : Multi-channel clamp / slew-limit / PS-code converter for the
//           fast-orbit-feedback power-supply DAC link (3-stage pipeline).
// Revision: 1.0
// ============================================================================
module ps_setpoint_converter #(
    parameter int DATA_W = 20,
    parameter int NCH    = 8,
    parameter int CH_W   = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_chan,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] lim_hi,
    input  logic [DATA_W-1:0] lim_lo,
    input  logic [DATA_W-2:0] max_step,
    input  logic              sat_clr,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_chan,
    output logic [DATA_W-1:0] out_data,
    output logic [NCH-1:0]    sat_flags
);

    localparam logic [DATA_W-1:0] c_max_pos = {1'b0, {(DATA_W-1){1'b1}}};

    logic              r_s1_valid;
    logic [CH_W-1:0]   r_s1_chan;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_hit;

    logic              r_s2_valid;
    logic [CH_W-1:0]   r_s2_chan;
    logic [DATA_W-1:0] r_s2_data;

    logic [DATA_W-1:0] r_last [NCH];

    logic [DATA_W-1:0]        w_clamp;
    logic                     w_clamp_hit;
    logic [DATA_W-1:0]        w_last;
    logic signed [DATA_W:0]   w_c_ext;
    logic signed [DATA_W:0]   w_last_ext;
    logic signed [DATA_W:0]   w_step;
    logic signed [DATA_W:0]   w_delta;
    logic signed [DATA_W:0]   w_slew;
    logic                     w_slew_hit;
    logic [NCH-1:0]           w_set_mask;
    logic [DATA_W-1:0]        w_code;

    // Upper limit is tested first so inverted limits resolve deterministically.
    always_comb begin
        w_clamp = in_data;
        if ($signed(in_data) > $signed(lim_hi))
            w_clamp = lim_hi;
        else if ($signed(in_data) < $signed(lim_lo))
            w_clamp = lim_lo;
    end
    assign w_clamp_hit = (w_clamp != in_data);

    assign w_last     = r_last[r_s1_chan];
    assign w_c_ext    = {r_s1_data[DATA_W-1], r_s1_data};
    assign w_last_ext = {w_last[DATA_W-1], w_last};
    assign w_step     = {2'b00, max_step};
    assign w_delta    = w_c_ext - w_last_ext;

    always_comb begin
        w_slew = w_c_ext;
        if (max_step != '0) begin
            if (w_delta > w_step)
                w_slew = w_last_ext + w_step;
            else if (w_delta < -w_step)
                w_slew = w_last_ext - w_step;
        end
    end
    assign w_slew_hit = (w_slew != w_c_ext);

    always_comb begin
        w_set_mask            = '0;
        w_set_mask[r_s1_chan] = r_s1_valid && (r_s1_hit || w_slew_hit);
    end

    // Legacy code maps the full-scale positive setpoint to itself.
    always_comb begin
        case (mode)
            2'd1:    w_code = r_s2_data[DATA_W-1] ? '0 : r_s2_data;
            2'd2:    w_code = (r_s2_data == c_max_pos) ? c_max_pos
                                                       : r_s2_data - c_max_pos;
            default: w_code = {~r_s2_data[DATA_W-1], r_s2_data[DATA_W-2:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_chan  <= '0;
            r_s1_data  <= '0;
            r_s1_hit   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_chan  <= '0;
            r_s2_data  <= '0;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            out_data   <= '0;
            sat_flags  <= '0;
            for (int i = 0; i < NCH; i++)
                r_last[i] <= '0;
        end else if (enb) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_chan <= in_chan;
                r_s1_data <= w_clamp;
                r_s1_hit  <= w_clamp_hit;
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_chan         <= r_s1_chan;
                r_s2_data         <= w_slew[DATA_W-1:0];
                r_last[r_s1_chan] <= w_slew[DATA_W-1:0];
            end
            sat_flags <= (sat_clr ? '0 : sat_flags) | w_set_mask;

            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                out_chan <= r_s2_chan;
                out_data <= w_code;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps_setpoint_converter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps_setpoint_converter
// Brief   : Directed self-checking bench for ps_setpoint_converter.
// Revision: 1.0
// ============================================================================
module tb_ps_setpoint_converter;

    localparam int DATA_W = 20;
    localparam int NCH    = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enb;
    logic              in_valid;
    logic [CH_W-1:0]   in_chan;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        mode;
    logic [DATA_W-1:0] lim_hi;
    logic [DATA_W-1:0] lim_lo;
    logic [DATA_W-2:0] max_step;
    logic              sat_clr;
    logic              out_valid;
    logic [CH_W-1:0]   out_chan;
    logic [DATA_W-1:0] out_data;
    logic [NCH-1:0]    sat_flags;

    int checks = 0;
    int errors = 0;
    int exp_c[$];
    int exp_d[$];

    ps_setpoint_converter #(.DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .enb(enb), .in_valid(in_valid),
        .in_chan(in_chan), .in_data(in_data), .mode(mode),
        .lim_hi(lim_hi), .lim_lo(lim_lo), .max_step(max_step),
        .sat_clr(sat_clr), .out_valid(out_valid), .out_chan(out_chan),
        .out_data(out_data), .sat_flags(sat_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, advance to the next falling edge, score any output.
    task automatic cyc(input logic v, input int ch, input int x);
        logic en;
        in_valid = v;
        in_chan  = ch[CH_W-1:0];
        in_data  = x[DATA_W-1:0];
        en       = enb;
        @(negedge clk);
        if (en && out_valid) begin
            if (exp_d.size() == 0)
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            else begin
                chk("sb_chan", {29'd0, out_chan}, exp_c.pop_front());
                chk("sb_data", {12'd0, out_data}, exp_d.pop_front());
            end
        end
    endtask

    task automatic push(input int ch, input int d);
        exp_c.push_back(ch);
        exp_d.push_back(d);
    endtask

    // Isolated sample: checks exact 3-cycle latency.
    task automatic run1(input string tag, input int ch, input int x, input int exp);
        in_valid = 1'b1;
        in_chan  = ch[CH_W-1:0];
        in_data  = x[DATA_W-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_chan"}, {29'd0, out_chan}, ch);
        chk({tag, "_data"}, {12'd0, out_data}, exp);
    endtask

    task automatic clear_flags();
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enb = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0;
        mode = 2'd0; lim_hi = 20'h7FFFF; lim_lo = 20'h80000; max_step = '0;
        sat_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_chan", {29'd0, out_chan}, 32'd0);
        chk("rst_data", {12'd0, out_data}, 32'd0);
        chk("rst_flags", {24'd0, sat_flags}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run1("zero_m0", 3, 0, 32'h80000);
        chk("zero_flags", {24'd0, sat_flags}, 32'd0);

        mode = 2'd0; run1("neg1_m0", 0, -1, 32'h7FFFF);
        mode = 2'd1; run1("neg1_m1", 0, -1, 32'h00000);
        mode = 2'd2; run1("neg1_m2", 0, -1, 32'h80000);
        run1("max_m2", 0, 32'h7FFFF, 32'h7FFFF);
        mode = 2'd3; run1("one_m3", 0, 1, 32'h80001);

        // Clamping and sticky flags
        mode = 2'd1; lim_hi = 20'd1000;
        run1("clamp_hi", 1, 5000, 1000);
        chk("clamp_flag", {24'd0, sat_flags}, 32'h02);
        clear_flags();
        chk("clr_flags", {24'd0, sat_flags}, 32'h00);
        in_valid = 1'b1; in_chan = 3'd1; in_data = 20'd5000;
        @(negedge clk);
        in_valid = 1'b0; sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_vs_set", {24'd0, sat_flags}, 32'h02);
        @(negedge clk);
        chk("clr_vs_set_data", {12'd0, out_data}, 1000);
        lim_hi = 20'h7FFFF;
        clear_flags();

        // Slew limiting: back-to-back same channel, then interleaved channels
        max_step = 19'd100;
        push(2, 100); push(2, 200); push(2, 300);
        cyc(1, 2, 1000); cyc(1, 2, 1000); cyc(1, 2, 1000);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        push(5, 100); push(2, 400); push(5, 200);
        cyc(1, 5, 500); cyc(1, 2, 1000); cyc(1, 5, 500);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("slew_drain", exp_d.size(), 0);
        chk("slew_flags", {24'd0, sat_flags}, 32'h24);

        // Clock-enable stall mid-stream
        max_step = '0;
        push(6, 10); push(7, 20); push(6, 30); push(7, 40);
        cyc(1, 6, 10); cyc(1, 7, 20); cyc(1, 6, 30);
        enb = 1'b0;
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("stall_hold", {12'd0, out_data}, 10);
        chk("stall_left", exp_d.size(), 3);
        enb = 1'b1;
        cyc(1, 7, 40);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("stall_drain", exp_d.size(), 0);

        // Async reset in the middle of a burst
        max_step = 19'd100;
        push(2, 500); push(2, 600); push(2, 700);
        cyc(1, 2, 1000); cyc(1, 2, 1000); cyc(1, 2, 1000);
        chk("burst_first_out", exp_d.size(), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {12'd0, out_data}, 32'd0);
        chk("arst_flags", {24'd0, sat_flags}, 32'd0);
        exp_c.delete(); exp_d.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run1("post_rst_slew", 2, 1000, 100);

        // Inverted limits: upper limit tested first
        max_step = '0; lim_lo = 20'd500; lim_hi = 20'd200;
        clear_flags();
        run1("inv_mid", 0, 300, 200);
        run1("inv_low", 0, 100, 500);
        chk("inv_flags", {24'd0, sat_flags}, 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
